// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory unit: MAR/MDR, on-chip word memory with configurable wait states,
// and the keyboard/display memory-mapped registers.
module lc3_mem_ctrl #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MEM_DEPTH   = 4096,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned MMIO_BASE   = 32'hFE00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              r_w,
  output logic [DATA_W-1:0] mdr_out,
  output logic              ready,
  output logic              addr_err,
  input  logic              kb_valid,
  input  logic [7:0]        kb_data,
  output logic              kb_ready,
  output logic              dsp_valid,
  output logic [7:0]        dsp_data,
  input  logic              dsp_ready
);

  localparam int unsigned MemAw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CntW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [ADDR_W-1:0] KbsrAddr = ADDR_W'(MMIO_BASE);
  localparam logic [ADDR_W-1:0] KbdrAddr = ADDR_W'(MMIO_BASE + 2);
  localparam logic [ADDR_W-1:0] DsrAddr  = ADDR_W'(MMIO_BASE + 4);
  localparam logic [ADDR_W-1:0] DdrAddr  = ADDR_W'(MMIO_BASE + 6);

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  state_e            state;
  logic [CntW-1:0]   cnt;
  logic              we;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [7:0]        kbdr;
  logic              kbsr;
  logic              dsr;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              sel_mem, sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, unmapped;
  logic [MemAw-1:0]  mem_idx;
  logic [DATA_W-1:0] rd_data;
  logic              rd_commit, wr_commit, kb_clear, kb_accept;

  always_comb begin
    sel_mem  = (32'(mar) < MEM_DEPTH);
    sel_kbsr = (mar == KbsrAddr);
    sel_kbdr = (mar == KbdrAddr);
    sel_dsr  = (mar == DsrAddr);
    sel_ddr  = (mar == DdrAddr);
    unmapped = !(sel_mem || sel_kbsr || sel_kbdr || sel_dsr || sel_ddr);
    mem_idx  = mar[MemAw-1:0];

    // Status registers expose only their flag, in the top bit of the word.
    rd_data = '0;
    if (sel_mem) begin
      rd_data = mem[mem_idx];
    end else if (sel_kbsr) begin
      rd_data[DATA_W-1] = kbsr;
    end else if (sel_kbdr) begin
      rd_data = DATA_W'(kbdr);
    end else if (sel_dsr) begin
      rd_data[DATA_W-1] = dsr;
    end
  end

  // ready is high exactly in the cycle whose closing edge commits the access.
  assign rd_commit = ready && !we;
  assign wr_commit = ready && we;
  assign kb_clear  = rd_commit && sel_kbdr;
  assign kb_accept = kb_valid && !kbsr && !kb_clear;
  assign kb_ready  = !rst && kb_accept;
  assign mdr_out   = mdr;

  always_ff @(posedge clk) begin
    if (wr_commit && sel_mem) begin
      mem[mem_idx] <= mdr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= '0;
      we        <= 1'b0;
      ready     <= 1'b0;
      mar       <= '0;
      mdr       <= '0;
      kbdr      <= '0;
      kbsr      <= 1'b0;
      dsr       <= 1'b1;
      addr_err  <= 1'b0;
      dsp_valid <= 1'b0;
      dsp_data  <= '0;
    end else begin
      if (ld_mar) begin
        mar <= bus_in[ADDR_W-1:0];
      end

      case (state)
        StIdle: begin
          if (mio_en) begin
            state <= StBusy;
            we    <= r_w;
            cnt   <= CntW'(WAIT_STATES);
            ready <= (WAIT_STATES == 0);
          end
        end
        StBusy: begin
          if (cnt != '0) begin
            cnt   <= cnt - CntW'(1);
            ready <= (cnt == CntW'(1));
          end else begin
            ready <= 1'b0;
            state <= StHold;
          end
        end
        StHold: begin
          if (!mio_en) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase

      if (rd_commit && ld_mdr) begin
        mdr <= rd_data;
      end else if (ld_mdr && !mio_en) begin
        mdr <= bus_in;
      end

      if (ready && unmapped) begin
        addr_err <= 1'b1;
      end

      if (kb_clear) begin
        kbsr <= 1'b0;
      end else if (kb_accept) begin
        kbdr <= kb_data;
        kbsr <= 1'b1;
      end

      if (wr_commit && sel_ddr) begin
        dsp_data  <= mdr[7:0];
        dsp_valid <= 1'b1;
        dsr       <= 1'b0;
      end else if (dsp_valid && dsp_ready) begin
        dsp_valid <= 1'b0;
        dsr       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl with default parameters (WAIT_STATES=2, MEM_DEPTH=4096).
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] mdr_out;
  logic        ready, addr_err;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        dsp_valid;
  logic [7:0]  dsp_data;
  logic        dsp_ready;

  int checks = 0;
  int errors = 0;

  lc3_mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus_in    (bus_in),
    .ld_mar    (ld_mar),
    .ld_mdr    (ld_mdr),
    .mio_en    (mio_en),
    .r_w       (r_w),
    .mdr_out   (mdr_out),
    .ready     (ready),
    .addr_err  (addr_err),
    .kb_valid  (kb_valid),
    .kb_data   (kb_data),
    .kb_ready  (kb_ready),
    .dsp_valid (dsp_valid),
    .dsp_data  (dsp_data),
    .dsp_ready (dsp_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus_in = v; ld_mar = 1'b1;
    step();
    ld_mar = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    bus_in = v; ld_mdr = 1'b1;
    step();
    ld_mdr = 1'b0;
  endtask

  // Runs one access; lat is the cycle count to ready (0 if it never came).
  task automatic run_access(input logic rw, input logic ldm, output int lat);
    mio_en = 1'b1; r_w = rw; ld_mdr = ldm;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (ready === 1'b1) begin
        lat = c;
        break;
      end
    end
    step();
    mio_en = 1'b0; ld_mdr = 1'b0; r_w = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (mdr_out !== 16'h0000) begin errors++; $display("FAIL reset_mdr got %h exp 0000", mdr_out); end
    checks++;
    if ({ready, addr_err, kb_ready, dsp_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {ready, addr_err, kb_ready, dsp_valid});
    end
    checks++;
    if (dsp_data !== 8'h00) begin errors++; $display("FAIL reset_dsp_data got %h exp 00", dsp_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_mem_rw();
    int lat;
    load_mar(16'h0010);
    load_mdr(16'hBEEF);
    checks++;
    if (mdr_out !== 16'hBEEF) begin errors++; $display("FAIL mdr_load got %h exp beef", mdr_out); end
    run_access(1'b1, 1'b0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL write_latency got %0d exp 3", lat); end
    load_mdr(16'h0000);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL read_latency got %0d exp 3", lat); end
    checks++;
    if (mdr_out !== 16'hBEEF) begin errors++; $display("FAIL read_back got %h exp beef", mdr_out); end
    // Top word of memory is still mapped.
    load_mar(16'h0FFF);
    load_mdr(16'h1234);
    run_access(1'b1, 1'b0, lat);
    load_mdr(16'h0000);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (mdr_out !== 16'h1234) begin errors++; $display("FAIL top_word got %h exp 1234", mdr_out); end
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL no_err_mapped got %b exp 0", addr_err); end
  endtask

  task automatic test_hold();
    int pulses;
    int lat;
    load_mar(16'h0010);
    load_mdr(16'h5555);
    mio_en = 1'b1; r_w = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
    mio_en = 1'b0;
    step();
    run_access(1'b1, 1'b0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL second_access got %0d exp 3", lat); end
    load_mdr(16'h0000);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (mdr_out !== 16'h5555) begin errors++; $display("FAIL hold_data got %h exp 5555", mdr_out); end
  endtask

  task automatic test_keyboard();
    int lat;
    logic seen;
    kb_valid = 1'b1; kb_data = 8'h41;
    #1;
    checks++;
    if (kb_ready !== 1'b1) begin errors++; $display("FAIL kb_accept got %b exp 1", kb_ready); end
    step();
    checks++;
    if (kb_ready !== 1'b0) begin errors++; $display("FAIL kb_full got %b exp 0", kb_ready); end
    kb_valid = 1'b0;
    load_mar(16'hFE00);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (mdr_out !== 16'h8000) begin errors++; $display("FAIL kbsr_set got %h exp 8000", mdr_out); end
    load_mar(16'hFE02);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (mdr_out !== 16'h0041) begin errors++; $display("FAIL kbdr_read got %h exp 0041", mdr_out); end
    load_mar(16'hFE00);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (mdr_out !== 16'h0000) begin errors++; $display("FAIL kbsr_clear got %h exp 0000", mdr_out); end
    // Offer a character exactly in the KBDR commit cycle: the clear must win.
    load_mar(16'hFE02);
    mio_en = 1'b1; r_w = 1'b0; ld_mdr = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    kb_valid = 1'b1; kb_data = 8'h42;
    #1;
    checks++;
    if ({seen, kb_ready} !== 2'b10) begin
      errors++; $display("FAIL kb_clear_wins got %b exp 10", {seen, kb_ready});
    end
    step();
    checks++;
    if (kb_ready !== 1'b1) begin errors++; $display("FAIL kb_next_cycle got %b exp 1", kb_ready); end
    mio_en = 1'b0; ld_mdr = 1'b0;
    step();
    kb_valid = 1'b0;
    step();
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (mdr_out !== 16'h0042) begin errors++; $display("FAIL kbdr_second got %h exp 0042", mdr_out); end
  endtask

  task automatic test_display();
    int lat;
    load_mar(16'hFE04);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (mdr_out !== 16'h8000) begin errors++; $display("FAIL dsr_idle got %h exp 8000", mdr_out); end
    load_mar(16'hFE06);
    load_mdr(16'h0058);
    run_access(1'b1, 1'b0, lat);
    checks++;
    if ({dsp_valid, dsp_data} !== 9'h158) begin
      errors++; $display("FAIL ddr_write got %h exp 158", {dsp_valid, dsp_data});
    end
    load_mar(16'hFE04);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (mdr_out !== 16'h0000) begin errors++; $display("FAIL dsr_busy got %h exp 0000", mdr_out); end
    dsp_ready = 1'b1;
    step();
    dsp_ready = 1'b0;
    checks++;
    if (dsp_valid !== 1'b0) begin errors++; $display("FAIL dsp_consume got %b exp 0", dsp_valid); end
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (mdr_out !== 16'h8000) begin errors++; $display("FAIL dsr_ready got %h exp 8000", mdr_out); end
  endtask

  task automatic test_addr_err();
    int lat;
    load_mar(16'h1000);
    load_mdr(16'h7777);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if ({addr_err, mdr_out} !== 17'h10000) begin
      errors++; $display("FAIL err_depth got %h exp 10000", {addr_err, mdr_out});
    end
    load_mar(16'h8000);
    load_mdr(16'h7777);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (mdr_out !== 16'h0000) begin errors++; $display("FAIL err_read got %h exp 0000", mdr_out); end
    load_mar(16'h0010);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if ({addr_err, mdr_out} !== 17'h15555) begin
      errors++; $display("FAIL err_sticky got %h exp 15555", {addr_err, mdr_out});
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int pulses;
    load_mar(16'h0020);
    load_mdr(16'h1111);
    run_access(1'b1, 1'b0, lat);
    load_mdr(16'h2222);
    mio_en = 1'b1; r_w = 1'b1;
    step();
    kb_valid = 1'b1; kb_data = 8'h33;
    rst = 1'b1;
    #1;
    checks++;
    if ({ready, addr_err, kb_ready, dsp_valid, dsp_data, mdr_out} !== 28'h0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0",
               {ready, addr_err, kb_ready, dsp_valid, dsp_data, mdr_out});
    end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ready === 1'b1) pulses++;
    end
    rst = 1'b0; mio_en = 1'b0; kb_valid = 1'b0;
    step();
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL reset_no_ready got %0d exp 0", pulses); end
    load_mar(16'h0020);
    run_access(1'b0, 1'b1, lat);
    checks++;
    if (mdr_out !== 16'h1111) begin errors++; $display("FAIL reset_no_write got %h exp 1111", mdr_out); end
  endtask

  initial begin
    bus_in = '0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0;
    kb_valid = 1'b0; kb_data = '0; dsp_ready = 1'b0; rst = 1'b1;
    test_reset();
    test_mem_rw();
    test_hold();
    test_keyboard();
    test_display();
    test_addr_err();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
